// File: rtl/amiga_timing_pkg.sv
// Shared A1000 bus timing definitions.
// Holds the bus phase constants, the phase type, and a decoder that maps a bus phase to the
// levels of the phase clocks and the DRAM row strobe. Has no ports.
package amiga_timing_pkg;

  localparam int unsigned BUS_PHASES = 8;

  typedef logic [2:0] phase_t;

  localparam phase_t PH_RAS_FALL  = 3'd1;
  localparam phase_t PH_COL_START = 3'd3;
  localparam phase_t PH_RAS_RISE  = 3'd7;
  localparam phase_t PH_LAST      = phase_t'(BUS_PHASES - 1);

  typedef struct packed {
    logic c1_n;
    logic c3_n;
    logic c4;
    logic c7m;
    logic ras_n;
  } bus_clk_t;

  localparam bus_clk_t BUS_CLK_RST = '{c1_n: 1'b1, c3_n: 1'b1, c4: 1'b0, c7m: 1'b0, ras_n: 1'b1};

  // Levels seen during phase ph, before any refresh override of C4.
  function automatic bus_clk_t phase_decode(phase_t ph);
    bus_clk_t o;
    o.c1_n  = ph[2];                                   // high for ph 4..7
    o.c3_n  = !((ph >= 3'd2) && (ph <= 3'd5));         // _C1 shifted by two phases
    o.c4    = (ph >= PH_COL_START) && (ph < PH_RAS_RISE);
    o.c7m   = !ph[1];                                  // high for ph 0,1,4,5
    o.ras_n = (ph < PH_RAS_FALL) || (ph >= PH_RAS_RISE);
    return o;
  endfunction

endpackage

// File: rtl/amiga_reset_sync.sv
// Two-flop reset synchronizer: asserts asynchronously, deasserts on the second clk_i edge
// after rst_ni rises.
//   clk_i  : clock of the destination domain
//   rst_ni : raw asynchronous active-low reset
//   rst_no : synchronized active-low reset
module amiga_reset_sync (
  input  logic clk_i,
  input  logic rst_ni,
  output logic rst_no
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign rst_no = sync_q[1];

endmodule

// File: rtl/amiga_a1000_clkgen.sv
// A1000 master timing sequencer. Divides C28M into the bus phase clocks and the DRAM row
// strobe, counts bus cycles per line and schedules RAS-only refresh slots.
//   c28m_i      : 28.63 MHz master clock
//   rst_ni      : asynchronous active-low reset
//   c1_n_o      : _C1, low in the first half of the bus cycle
//   c3_n_o      : _C3, _C1 delayed a quarter cycle
//   c4_o        : row/column select (1 = column), held 0 in refresh slots
//   c7m_o       : 7.16 MHz clock
//   ras_n_o     : DRAM row strobe, active low
//   refslot_n_o : low for the whole bus cycle of a refresh slot
//   rfaddr_o    : refresh row address
//   hpos_o      : bus cycle within the line
module amiga_a1000_clkgen
  import amiga_timing_pkg::*;
#(
  parameter int unsigned LINE_CYCLES   = 227,
  parameter int unsigned REFRESH_START = 1,
  parameter int unsigned REFRESH_SLOTS = 4
) (
  input  logic       c28m_i,
  input  logic       rst_ni,
  output logic       c1_n_o,
  output logic       c3_n_o,
  output logic       c4_o,
  output logic       c7m_o,
  output logic       ras_n_o,
  output logic       refslot_n_o,
  output logic [7:0] rfaddr_o,
  output logic [7:0] hpos_o
);

  if ((LINE_CYCLES > 256) || (LINE_CYCLES == 0)) begin : gen_bad_line
    $error("LINE_CYCLES must be in 1..256");
  end
  if ((REFRESH_SLOTS > 0) && (REFRESH_START + 2 * (REFRESH_SLOTS - 1) >= LINE_CYCLES))
  begin : gen_bad_refresh
    $error("refresh slots do not fit in the line");
  end

  localparam logic [7:0] HPOS_MAX = 8'(LINE_CYCLES - 1);

  function automatic logic is_refresh(logic [7:0] h);
    int diff;
    if (REFRESH_SLOTS == 0) return 1'b0;
    diff = int'({24'd0, h}) - int'(REFRESH_START);
    if (diff < 0) return 1'b0;
    return !diff[0] && ((diff >>> 1) < int'(REFRESH_SLOTS));
  endfunction

  logic rst_sync_n;

  amiga_reset_sync u_reset_sync (
    .clk_i  (c28m_i),
    .rst_ni (rst_ni),
    .rst_no (rst_sync_n)
  );

  // run_q low means the next edge is the first entry into phase 0 of HPOS 0.
  logic       run_q, run_d;
  phase_t     ph_q, ph_d;
  logic [7:0] hpos_q, hpos_d;
  logic [7:0] rfaddr_q, rfaddr_d;
  logic       refslot_n_q, refslot_n_d;
  bus_clk_t   clk_q, clk_d;
  logic       cycle_end;

  always_comb begin
    run_d       = 1'b1;
    ph_d        = run_q ? ph_q + 3'd1 : 3'd0;
    cycle_end   = run_q && (ph_q == PH_LAST);
    hpos_d      = hpos_q;
    rfaddr_d    = rfaddr_q;
    refslot_n_d = refslot_n_q;
    if (cycle_end) begin
      hpos_d = (hpos_q == HPOS_MAX) ? 8'd0 : hpos_q + 8'd1;
      if (!refslot_n_q) rfaddr_d = rfaddr_q + 8'd1;
    end
    // The slot decision is taken on the new HPOS, including the very first cycle.
    if (cycle_end || !run_q) refslot_n_d = !is_refresh(hpos_d);
    clk_d = phase_decode(ph_d);
    // Keep the row address on the bus for RAS-only refresh.
    if (!refslot_n_d) clk_d.c4 = 1'b0;
  end

  always_ff @(posedge c28m_i or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      run_q       <= 1'b0;
      ph_q        <= 3'd0;
      hpos_q      <= 8'd0;
      rfaddr_q    <= 8'd0;
      refslot_n_q <= 1'b1;
      clk_q       <= BUS_CLK_RST;
    end else begin
      run_q       <= run_d;
      ph_q        <= ph_d;
      hpos_q      <= hpos_d;
      rfaddr_q    <= rfaddr_d;
      refslot_n_q <= refslot_n_d;
      clk_q       <= clk_d;
    end
  end

  assign c1_n_o      = clk_q.c1_n;
  assign c3_n_o      = clk_q.c3_n;
  assign c4_o        = clk_q.c4;
  assign c7m_o       = clk_q.c7m;
  assign ras_n_o     = clk_q.ras_n;
  assign refslot_n_o = refslot_n_q;
  assign rfaddr_o    = rfaddr_q;
  assign hpos_o      = hpos_q;

endmodule

// File: tb/tb_amiga_a1000_clkgen.sv
// Bench for amiga_a1000_clkgen: four instances with different line/refresh settings share clock
// and a randomly pulsed reset. Expected outputs come from an arithmetic model of elapsed ticks.
module tb_amiga_a1000_clkgen;

  typedef struct packed {
    logic       c1_n;
    logic       c3_n;
    logic       c4;
    logic       c7m;
    logic       ras_n;
    logic       ref_n;
    logic [7:0] rf;
    logic [7:0] hp;
  } obs_t;

  typedef obs_t [3:0] quad_t;

  localparam int unsigned P_LINE  [4] = '{227, 10, 8, 5};
  localparam int unsigned P_START [4] = '{1, 9, 0, 0};
  localparam int unsigned P_SLOTS [4] = '{4, 1, 4, 0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  obs_t act [4];

  for (genvar i = 0; i < 4; i++) begin : g_dut
    logic       c1_n, c3_n, c4, c7m, ras_n, ref_n;
    logic [7:0] rf, hp;
    amiga_a1000_clkgen #(
      .LINE_CYCLES   (P_LINE[i]),
      .REFRESH_START (P_START[i]),
      .REFRESH_SLOTS (P_SLOTS[i])
    ) u_dut (
      .c28m_i      (clk),
      .rst_ni      (rst_n),
      .c1_n_o      (c1_n),
      .c3_n_o      (c3_n),
      .c4_o        (c4),
      .c7m_o       (c7m),
      .ras_n_o     (ras_n),
      .refslot_n_o (ref_n),
      .rfaddr_o    (rf),
      .hpos_o      (hp)
    );
    assign act[i] = {c1_n, c3_n, c4, c7m, ras_n, ref_n, rf, hp};
  end

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned edges = 0;   // rising edges seen with reset released
  bit          started = 1'b0;
  quad_t       exp_q[$];

  // Expected outputs after `e` edges since reset release, from the timing rules directly.
  function automatic obs_t model(int unsigned e, logic rst, int unsigned line,
                                 int unsigned start, int unsigned slots);
    obs_t        o;
    int unsigned t, ph, cyc, hp, lines, done;
    bit          insl;
    o.c1_n = 1'b1; o.c3_n = 1'b1; o.c4 = 1'b0; o.c7m = 1'b0; o.ras_n = 1'b1; o.ref_n = 1'b1;
    o.rf = 8'd0; o.hp = 8'd0;
    if (!rst || e < 3) return o;
    t     = e - 3;
    ph    = t % 8;
    cyc   = t / 8;
    hp    = cyc % line;
    lines = cyc / line;
    insl  = (slots > 0) && (hp >= start) && ((hp - start) % 2 == 0) && ((hp - start) / 2 < slots);
    done  = lines * slots;
    for (int k = 0; k < int'(slots); k++) if (start + 2 * k < hp) done++;
    o.c1_n  = (ph >= 4);
    o.c3_n  = !(ph >= 2 && ph <= 5);
    o.c7m   = (ph % 4) < 2;
    o.ras_n = (ph == 7) || (ph == 0);
    o.c4    = (ph >= 3) && (ph <= 6) && !insl;
    o.ref_n = !insl;
    o.rf    = 8'(done % 256);
    o.hp    = 8'(hp);
    return o;
  endfunction

  // One clock tick: count the edge, change reset between edges, queue what to expect.
  task automatic tick(input logic r);
    quad_t q;
    @(posedge clk);
    if (rst_n) edges++;
    #2;
    rst_n = r;
    if (!r) edges = 0;
    for (int i = 0; i < 4; i++) q[i] = model(edges, r, P_LINE[i], P_START[i], P_SLOTS[i]);
    exp_q.push_back(q);
    started = 1'b1;
  endtask

  task automatic run(input int unsigned n);
    repeat (n) tick(1'b1);
  endtask

  task automatic pulse(input int unsigned n);
    repeat (n) tick(1'b0);
  endtask

  always @(negedge clk) begin
    quad_t e;
    if (started) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_underflow at %0t: got empty queue, required an entry", $time);
      end else begin
        e = exp_q.pop_front();
        for (int i = 0; i < 4; i++) begin
          n_checks++;
          if (act[i] !== e[i]) begin
            n_fail++;
            $display({"FAIL dut%0d_outputs at %0t: got c1n=%b c3n=%b c4=%b c7m=%b rasn=%b ",
                      "refn=%b rf=%0d hpos=%0d, required c1n=%b c3n=%b c4=%b c7m=%b rasn=%b ",
                      "refn=%b rf=%0d hpos=%0d"}, i, $time,
                     act[i].c1_n, act[i].c3_n, act[i].c4, act[i].c7m, act[i].ras_n,
                     act[i].ref_n, act[i].rf, act[i].hp,
                     e[i].c1_n, e[i].c3_n, e[i].c4, e[i].c7m, e[i].ras_n,
                     e[i].ref_n, e[i].rf, e[i].hp);
          end
        end
      end
    end
  end

  initial begin
    pulse(3);
    run(2000);             // full line of the 227-cycle instance, including the wrap
    pulse(2);
    run(15);               // reset lands in ph 4 of the HPOS 1 refresh slot
    pulse(1);
    for (int ep = 0; ep < 20; ep++) begin
      run($urandom_range(20, 1200));
      pulse($urandom_range(1, 3));
    end
    run(4300);             // 8-cycle line instance passes 256 refresh slots
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of stimulus, required end before time limit");
    $fatal(1, "timeout");
  end

endmodule
